// File: rtl/group_serial_subtractor.sv
// group_serial_subtractor
//
// Multi-cycle subtractor: result = a - b - bin, computed GROUPSIZE bits per
// clock starting from the least-significant group. The operands are captured
// on accept. The result is presented with valid/ready handshakes on both sides.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid
//   in_ready   block accepts operands (only in IDLE)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow-in
//   out_valid  result valid (only in DONE)
//   out_ready  consumer accepts result
//   result     [WIDTH-1:0] = a-b-bin mod 2^WIDTH, [WIDTH] = borrow-out
//   zero       result[WIDTH-1:0] == 0 (meaningful while out_valid)
//   ovf        signed overflow of the subtraction (meaningful while out_valid)

module group_serial_subtractor #(
  parameter int WIDTH     = 64,
  parameter int GROUPSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             ovf
);

  localparam int NUM_GROUPS = WIDTH / GROUPSIZE;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 borrow_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH:0]       result_reg;
  logic                 zero_reg;
  logic                 ovf_reg;

  // Captured operands viewed as an array of groups so the active group can
  // be selected directly by the group counter.
  logic [GROUPSIZE-1:0] a_grp [NUM_GROUPS];
  logic [GROUPSIZE-1:0] b_grp [NUM_GROUPS];

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_split
    assign a_grp[gi] = a_reg[gi*GROUPSIZE +: GROUPSIZE];
    assign b_grp[gi] = b_reg[gi*GROUPSIZE +: GROUPSIZE];
  end

  logic [GROUPSIZE:0]   grp_full;
  logic                 borrow_next;
  logic [WIDTH-1:0]     res_body_next;
  logic                 zero_next;
  logic                 ovf_next;

  // One group step. The subtraction uses one extra bit, and that top bit is
  // set exactly when the group difference goes negative, i.e. the borrow out.
  always_comb begin
    grp_full      = {1'b0, a_grp[cnt_reg]} - {1'b0, b_grp[cnt_reg]}
                    - {{GROUPSIZE{1'b0}}, borrow_reg};
    borrow_next   = grp_full[GROUPSIZE];
    res_body_next = result_reg[WIDTH-1:0];
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (cnt_reg == CNT_W'(g)) begin
        res_body_next[g*GROUPSIZE +: GROUPSIZE] = grp_full[GROUPSIZE-1:0];
      end
    end
    zero_next = (res_body_next == '0);
    ovf_next  = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                (res_body_next[WIDTH-1] != a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;   // group 0 consumes the external borrow-in
            cnt_reg    <= '0;
            result_reg <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          result_reg[WIDTH-1:0] <= res_body_next;
          borrow_reg            <= borrow_next;
          cnt_reg               <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_GROUP) begin
            // The flags are computed from the completed word as it enters DONE.
            // They then hold until the consumer takes the result.
            result_reg[WIDTH] <= borrow_next;
            zero_reg          <= zero_next;
            ovf_reg           <= ovf_next;
            cnt_reg           <= '0;
            state_reg         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode directly from the registered state. in_ready is
  // therefore low during the DONE hand-off cycle, so no accept can happen
  // in that same cycle.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_group_serial_subtractor.sv
// Testbench for group_serial_subtractor (WIDTH=64, GROUPSIZE=8).
// Directed and random operands are compared against a plain 65-bit
// arithmetic reference. The bench also checks handshake timing, output hold
// under back-pressure, and reset abort.

module tb_group_serial_subtractor;

  localparam int W  = 64;
  localparam int G  = 8;
  localparam int NG = W / G;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    result;
  logic          zero;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  group_serial_subtractor #(.WIDTH(W), .GROUPSIZE(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    bin      = 1'($urandom);
    in_valid = 1'($urandom);
  endtask

  // One complete operation. Inputs are scrambled after the accept to show
  // that the captured operands are used and that in_valid is ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input int hold);
    logic [W:0] exp_res;
    logic       exp_zero;
    logic       exp_ovf;
    exp_res  = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    exp_zero = (exp_res[W-1:0] == '0);
    exp_ovf  = (ta[W-1] != tb_v[W-1]) && (exp_res[W-1] != ta[W-1]);

    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", {{W{1'b0}}, in_ready}, 65'd1);
    @(posedge clk);  // accepting edge
    for (int i = 0; i <= NG; i++) begin
      @(negedge clk);
      check("out_valid_timing", {{W{1'b0}}, out_valid}, {{W{1'b0}}, (i == NG)});
      if (i < NG) begin
        check("in_ready_run", {{W{1'b0}}, in_ready}, 65'd0);
        scramble_inputs();
      end
    end
    check("result",    result,                  exp_res);
    check("zero",      {{W{1'b0}}, zero},       {{W{1'b0}}, exp_zero});
    check("ovf",       {{W{1'b0}}, ovf},        {{W{1'b0}}, exp_ovf});

    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      @(negedge clk);
      check("hold_result",    result,                     exp_res);
      check("hold_zero",      {{W{1'b0}}, zero},          {{W{1'b0}}, exp_zero});
      check("hold_ovf",       {{W{1'b0}}, ovf},           {{W{1'b0}}, exp_ovf});
      check("hold_out_valid", {{W{1'b0}}, out_valid},     65'd1);
      check("hold_in_ready",  {{W{1'b0}}, in_ready},      65'd0);
    end

    // Release with in_valid high: the handshake cycle must not accept.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    check("release_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
    check("release_in_ready",  {{W{1'b0}}, in_ready},  65'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    $display("op a=%h b=%h bin=%0d -> result=%h zero=%0d ovf=%0d (expected %h %0d %0d)",
             ta, tb_v, tbin, result, zero, ovf, exp_res, exp_zero, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready",  {{W{1'b0}}, in_ready},  65'd1);
    check("reset_out_valid", {{W{1'b0}}, out_valid}, 65'd0);
    check("reset_result",    result,                 65'd0);
    check("reset_zero",      {{W{1'b0}}, zero},      65'd0);
    check("reset_ovf",       {{W{1'b0}}, ovf},       65'd0);

    // Directed cases
    run_op(64'd100, 64'd58, 1'b0, 0);
    run_op(64'd0, 64'd1, 1'b0, 0);
    run_op(64'd5, 64'd4, 1'b1, 0);
    run_op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5);

    // Reset during RUN cycle 4 aborts the operation
    @(negedge clk);
    a = 64'd77; b = 64'd11; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {{W{1'b0}}, in_ready}, 65'd1);
    check("abort_result",   result,                65'd0);
    for (int i = 0; i < NG + 2; i++) begin
      check("abort_no_valid", {{W{1'b0}}, out_valid}, 65'd0);
      @(negedge clk);
    end
    $display("reset abort sequence done");
    run_op(64'd1000, 64'd1, 1'b0, 1);

    // Random operands, occasionally with back-pressure
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (n % 6 == 0) ? ra : {$urandom, $urandom};
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
